// File: rtl/mantissa_align.sv
// mantissa_align: orders two FP operands by magnitude and right-aligns the smaller mantissa with guard/sticky.
// Define MANTISSA_ALIGN_STICKY_EN to accumulate sticky; otherwise sticky is tied to 0.
module mantissa_align (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  exp_a,
  input  logic [7:0]  exp_b,
  input  logic [23:0] mant_a,
  input  logic [23:0] mant_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  exp_out,
  output logic [23:0] mant_big,
  output logic [23:0] mant_small,
  output logic        guard,
  output logic        sticky,
  output logic        swapped
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [7:0]  exp_q, exp_d, diff;
  logic [23:0] big_q, big_d, small_q, small_d;
  logic        guard_q, guard_d, swap_q, swap_d, swap_in;
  logic [4:0]  cnt_q, cnt_d;
  always_comb begin
    swap_in = (exp_b > exp_a) || (exp_b == exp_a && mant_b > mant_a);
    diff    = swap_in ? exp_b - exp_a : exp_a - exp_b;
    state_d = state_q;
    exp_d   = exp_q;
    big_d   = big_q;
    small_d = small_q;
    guard_d = guard_q;
    swap_d  = swap_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = SHIFT;
        exp_d   = swap_in ? exp_b : exp_a;
        big_d   = swap_in ? mant_b : mant_a;
        small_d = swap_in ? mant_a : mant_b;
        guard_d = 1'b0;
        swap_d  = swap_in;
        cnt_d   = diff > 8'd25 ? 5'd25 : diff[4:0];
      end
      SHIFT: if (cnt_q == 5'd0) state_d = DONE;
        else begin
          {small_d, guard_d} = {1'b0, small_q};
          cnt_d = cnt_q - 5'd1;
        end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      exp_q   <= '0;
      big_q   <= '0;
      small_q <= '0;
      guard_q <= 1'b0;
      swap_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      big_q   <= big_d;
      small_q <= small_d;
      guard_q <= guard_d;
      swap_q  <= swap_d;
      cnt_q   <= cnt_d;
    end
  end
`ifdef MANTISSA_ALIGN_STICKY_EN
  logic sticky_q, sticky_d;
  always_comb begin
    sticky_d = (state_q == IDLE && in_valid) ? 1'b0 :
               (state_q == SHIFT && cnt_q != 5'd0) ? (sticky_q | guard_q) : sticky_q;
  end
  always_ff @(posedge clk) begin
    if (rst) sticky_q <= 1'b0;
    else sticky_q <= sticky_d;
  end
  assign sticky = sticky_q;
`else
  assign sticky = 1'b0;
`endif
  assign in_ready   = state_q == IDLE;
  assign out_valid  = state_q == DONE;
  assign exp_out    = exp_q;
  assign mant_big   = big_q;
  assign mant_small = small_q;
  assign guard      = guard_q;
  assign swapped    = swap_q;
endmodule

// File: tb/tb_mantissa_align.sv
// tb_mantissa_align: randomized and directed checks of mantissa_align against a wide-shift reference model.
module tb_mantissa_align;
  logic clk = 0, rst = 0, in_valid = 0, out_ready = 0;
  logic [7:0] exp_a = 0, exp_b = 0, exp_out;
  logic [23:0] mant_a = 0, mant_b = 0, mant_big, mant_small;
  logic in_ready, out_valid, guard, sticky, swapped;
  int checks = 0, errors = 0;

  mantissa_align dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .exp_a(exp_a), .exp_b(exp_b), .mant_a(mant_a), .mant_b(mant_b), .out_valid(out_valid),
    .out_ready(out_ready), .exp_out(exp_out), .mant_big(mant_big), .mant_small(mant_small),
    .guard(guard), .sticky(sticky), .swapped(swapped));

  always #5 clk = ~clk;

  typedef struct {logic [58:0] v; int lat;} res_t;

  wire [58:0] obs = {exp_out, mant_big, mant_small, guard, sticky, swapped};

  // Reference: shift the small mantissa in a 49-bit field so guard/sticky fall out as plain bit slices.
  function automatic res_t model(input [7:0] ea, input [23:0] ma, input [7:0] eb, input [23:0] mb);
    res_t r;
    logic sw, st;
    logic [48:0] ext;
    int diff, d;
    sw = (eb > ea) || (eb == ea && mb > ma);
    diff = sw ? int'(eb) - int'(ea) : int'(ea) - int'(eb);
    d = diff > 25 ? 25 : diff;
    ext = {(sw ? ma : mb), 25'b0} >> d;
`ifdef MANTISSA_ALIGN_STICKY_EN
    st = |ext[23:0];
`else
    st = 1'b0;
`endif
    r.v = {(sw ? eb : ea), (sw ? mb : ma), ext[48:25], ext[24], st, sw};
    r.lat = 1 + d;
    return r;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic start(input [7:0] ea, input [23:0] ma, input [7:0] eb, input [23:0] mb);
    exp_a = ea; mant_a = ma; exp_b = eb; mant_b = mb; in_valid = 1;
    step;
    in_valid = 0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      step;
      if (out_valid) begin lat = i; break; end
    end
  endtask

  task automatic consume;
    out_ready = 1;
    step;
    out_ready = 0;
  endtask

  task automatic test_reset;
    rst = 1; step; rst = 0;
    checks++;
    if ({in_ready, out_valid, obs} !== {2'b10, 59'd0}) begin
      errors++; $display("FAIL reset: got rdy=%b vld=%b out=%h, want rdy=1 vld=0 out=0", in_ready, out_valid, obs);
    end
  endtask

  task automatic test_directed;
    logic [7:0]  ea [7] = '{8'd130, 8'd100, 8'd127, 8'd127, 8'd90, 8'd200, 8'd1};
    logic [23:0] ma [7] = '{24'hC00000, 24'h800001, 24'h800000, 24'h812345, 24'hFFFFFF, 24'h800000, 24'hABCDEF};
    logic [7:0]  eb [7] = '{8'd128, 8'd127, 8'd127, 8'd127, 8'd65, 8'd201, 8'd255};
    logic [23:0] mb [7] = '{24'h800003, 24'hA00000, 24'h900000, 24'h812345, 24'hFFFFFF, 24'h800001, 24'h800000};
    res_t e;
    int lat;
    for (int i = 0; i < 7; i++) begin
      e = model(ea[i], ma[i], eb[i], mb[i]);
      start(ea[i], ma[i], eb[i], mb[i]);
      wait_done(lat);
      checks++;
      if (lat !== e.lat) begin
        errors++; $display("FAIL directed[%0d] latency: got %0d want %0d", i, lat, e.lat);
      end
      checks++;
      if (obs !== e.v) begin
        errors++; $display("FAIL directed[%0d] result: got %h want %h", i, obs, e.v);
      end
      consume;
      checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
        errors++; $display("FAIL directed[%0d] release: got rdy=%b vld=%b want 1 0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_backpressure;
    res_t e;
    int lat;
    logic [58:0] snap;
    e = model(8'd130, 24'hC00000, 8'd128, 24'h800003);
    start(8'd130, 24'hC00000, 8'd128, 24'h800003);
    wait_done(lat);
    snap = obs;
    checks++;
    if (snap !== e.v) begin
      errors++; $display("FAIL backpressure result: got %h want %h", snap, e.v);
    end
    exp_a = 8'd5; mant_a = 24'h123456; exp_b = 8'd9; mant_b = 24'h654321; in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      step;
      checks++;
      if ({obs, in_ready, out_valid} !== {e.v, 2'b01}) begin
        errors++; $display("FAIL backpressure hold[%0d]: got out=%h rdy=%b vld=%b want out=%h rdy=0 vld=1", i, obs, in_ready, out_valid, e.v);
      end
    end
    out_ready = 1; step; out_ready = 0; in_valid = 0;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++; $display("FAIL backpressure release: got rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_shift;
    int seen = 0;
    start(8'd110, 24'hFFFFFF, 8'd100, 24'hFFFFFF);
    step; step; step;
    rst = 1; step; rst = 0;
    checks++;
    if ({in_ready, out_valid, obs} !== {2'b10, 59'd0}) begin
      errors++; $display("FAIL reset_mid_shift: got rdy=%b vld=%b out=%h want rdy=1 vld=0 out=0", in_ready, out_valid, obs);
    end
    for (int i = 0; i < 30; i++) begin
      step;
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL reset_mid_shift valid: got %0d valid cycles want 0", seen);
    end
  endtask

  task automatic test_reset_handshake;
    int seen = 0;
    exp_a = 8'd50; mant_a = 24'hFFFFFF; exp_b = 8'd40; mant_b = 24'hFFFFFF;
    rst = 1; in_valid = 1; step; rst = 0; in_valid = 0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid || !in_ready) seen++;
      step;
    end
    checks++;
    if (seen !== 0 || obs !== 59'd0) begin
      errors++; $display("FAIL reset_handshake: got %0d busy cycles out=%h want 0 busy out=0", seen, obs);
    end
  endtask

  task automatic test_random;
    logic [7:0] ea, eb;
    logic [23:0] ma, mb;
    res_t e;
    int lat;
    for (int i = 0; i < 60; i++) begin
      ea = 8'($urandom);
      eb = (i % 3 == 0) ? 8'($urandom) : 8'(int'(ea) + $urandom_range(0, 30) - 15);
      ma = {1'b1, 23'($urandom)};
      mb = (i % 7 == 0) ? ma : {1'b1, 23'($urandom)};
      e = model(ea, ma, eb, mb);
      start(ea, ma, eb, mb);
      wait_done(lat);
      checks++;
      if (lat !== e.lat || obs !== e.v) begin
        errors++; $display("FAIL random[%0d] ea=%0d ma=%h eb=%0d mb=%h: got lat=%0d out=%h want lat=%0d out=%h", i, ea, ma, eb, mb, lat, obs, e.lat, e.v);
      end
      consume;
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_backpressure;
    test_reset_mid_shift;
    test_reset_handshake;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
